// File: rtl/ser_pkg.sv
// Definitions shared by the serializer and the receiving shift register.
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int SER_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: takes a word on a valid/ready handshake
// and shifts it out LSB first, one bit per EN-qualified clock.
module piso_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH = SER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             EN,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  ser_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             final_shift;

  // The edge that consumes the last bit can also accept the next word.
  assign final_shift = (state == SHIFT) && EN && (cnt == LAST_BIT);
  assign load_ready  = (state == IDLE) || final_shift;

  assign sout       = shreg[0];
  assign busy       = (state == SHIFT);
  assign sout_valid = busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            shreg <= load_data;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (EN) begin
            if (cnt == LAST_BIT) begin
              done <= 1'b1;
              if (load_valid) begin
                shreg <= load_data;
                cnt   <= '0;
              end else begin
                shreg <= '0;
                cnt   <= '0;
                state <= IDLE;
              end
            end else begin
              shreg <= {1'b0, shreg[WIDTH-1:1]};
              cnt   <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_cnt_bound: assert property (@(posedge clk) disable iff (reset) cnt <= LAST_BIT);
  a_done_pulse: assert property (@(posedge clk) disable iff (reset) done |=> !done);

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed scenarios plus a random
// run compared against a bit-queue reference model.
module tb_piso_serializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic         load_ready;
  logic         EN = 1'b0;
  logic         sout;
  logic         sout_valid;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: bits still to be sent, oldest first.
  logic   mq[$];
  logic   m_busy = 1'b0;
  logic   m_done = 1'b0;
  logic   m_sout = 1'b0;
  logic [W-1:0] rq;

  piso_serializer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .EN(EN), .sout(sout), .sout_valid(sout_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic lv, input logic [W-1:0] d, input logic en);
    load_valid = lv;
    load_data  = d;
    EN         = en;
    #1;
  endtask

  // Advance one clock, updating the reference model and the paired receiver.
  task automatic tick();
    logic rdy, fin, acc;
    rdy = !m_busy || (EN && mq.size() == 1);
    fin = m_busy && EN && mq.size() == 1;
    acc = rdy && load_valid;
    if (EN) rq = {sout, rq[W-1:1]};
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_busy = 1'b0;
      m_done = 1'b0;
    end else begin
      m_done = fin;
      if (m_busy && EN) void'(mq.pop_front());
      if (acc) begin
        for (int i = 0; i < W; i++) mq.push_back(load_data[i]);
        m_busy = 1'b1;
      end else if (mq.size() == 0) begin
        m_busy = 1'b0;
      end
    end
    m_sout = (mq.size() != 0) ? mq[0] : 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, '0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b exp 1", load_ready); end
    n_cmp++; if (sout_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", sout_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", done); end
    n_cmp++; if (sout !== 1'b0) begin n_bad++; $display("FAIL reset_sout got %b exp 0", sout); end
  endtask

  task automatic test_basic();
    logic [W-1:0] exp_bits;
    exp_bits = 4'b1011;
    drive(1'b1, 4'b1011, 1'b1);
    tick();
    rq = 4'b1010;
    for (int k = 0; k < W; k++) begin
      n_cmp++; if (sout !== exp_bits[k] || sout_valid !== 1'b1) begin
        n_bad++; $display("FAIL basic_sout c%0d got %b/%b exp %b/1", k + 1, sout, sout_valid, exp_bits[k]);
      end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_early_done c%0d got %b exp 0", k + 1, done); end
      drive(1'b0, '0, 1'b1);
      tick();
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL basic_done got %b exp 1", done); end
    n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready got %b exp 1", load_ready); end
    n_cmp++; if (rq !== 4'b1011) begin n_bad++; $display("FAIL basic_receiver got %b exp 1011", rq); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_width got %b exp 0", done); end
  endtask

  task automatic test_en_gaps();
    logic [6:0]   pat;
    logic [W-1:0] got;
    int           n_en;
    pat  = 7'b1011001;  // applied from bit 0 upward: 1,0,0,1,1,0,1
    got  = '0;
    n_en = 0;
    drive(1'b1, 4'b0110, 1'b1);
    tick();
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, '0, pat[i]);
      n_cmp++; if (sout !== m_sout || sout_valid !== 1'b1) begin
        n_bad++; $display("FAIL gaps_sout c%0d got %b/%b exp %b/1", i + 1, sout, sout_valid, m_sout);
      end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL gaps_early_done c%0d got %b exp 0", i + 1, done); end
      if (pat[i]) begin
        got[n_en] = sout;
        n_en++;
      end
      tick();
    end
    n_cmp++; if (got !== 4'b0110) begin n_bad++; $display("FAIL gaps_bits got %b exp 0110", got); end
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL gaps_done got done=%b busy=%b exp 1/0", done, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_seq;
    logic [7:0] got;
    exp_seq = 8'b00111001;  // bit i is the expected sout in cycle i+1
    got = '0;
    drive(1'b1, 4'b1001, 1'b1);
    tick();
    for (int c = 1; c <= 10; c++) begin
      drive(c <= 4, 4'b0011, 1'b1);
      if (c <= 8) begin
        got[c-1] = sout;
        n_cmp++; if (sout_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid c%0d got %b exp 1", c, sout_valid); end
      end
      n_cmp++; if (done !== (c == 5 || c == 9)) begin
        n_bad++; $display("FAIL b2b_done c%0d got %b exp %b", c, done, (c == 5 || c == 9));
      end
      tick();
    end
    n_cmp++; if (got !== exp_seq) begin n_bad++; $display("FAIL b2b_seq got %b exp %b", got, exp_seq); end
  endtask

  task automatic test_load_busy();
    logic [W-1:0] got;
    got = '0;
    drive(1'b1, 4'b0001, 1'b1);
    tick();
    for (int c = 1; c <= 4; c++) begin
      drive(c == 2, 4'b1111, 1'b1);
      if (c == 2) begin
        n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL busy_ready got %b exp 0", load_ready); end
      end
      got[c-1] = sout;
      tick();
    end
    n_cmp++; if (got !== 4'b0001) begin n_bad++; $display("FAIL busy_seq got %b exp 0001", got); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b1) begin
      n_bad++; $display("FAIL busy_end got busy=%b done=%b exp 0/1", busy, done);
    end
    drive(1'b0, '0, 1'b1);
    tick();
    n_cmp++; if (sout_valid !== 1'b0) begin n_bad++; $display("FAIL busy_ignored got %b exp 0", sout_valid); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] got;
    drive(1'b1, 4'b1100, 1'b1);
    tick();
    drive(1'b0, '0, 1'b1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, '0, 1'b0);
    n_cmp++; if (sout !== 1'b0 || sout_valid !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL midreset_state got sout=%b vld=%b busy=%b rdy=%b done=%b exp 0/0/0/1/0",
                        sout, sout_valid, busy, load_ready, done);
    end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midreset_done got %b exp 0", done); end
    drive(1'b1, 4'b0101, 1'b1);
    tick();
    got = '0;
    for (int c = 0; c < W; c++) begin
      drive(1'b0, '0, 1'b1);
      got[c] = sout;
      tick();
    end
    n_cmp++; if (got !== 4'b0101 || done !== 1'b1) begin
      n_bad++; $display("FAIL midreset_reload got %b done=%b exp 0101 done=1", got, done);
    end
  endtask

  task automatic test_random();
    logic exp_rdy;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 2) != 0, W'($urandom), $urandom_range(0, 3) != 0);
      exp_rdy = !m_busy || (EN && mq.size() == 1);
      n_cmp++; if (load_ready !== exp_rdy) begin
        n_bad++; $display("FAIL rand_ready i%0d got %b exp %b", i, load_ready, exp_rdy);
      end
      tick();
      n_cmp++; if (sout !== m_sout || sout_valid !== m_busy || busy !== m_busy || done !== m_done) begin
        n_bad++; $display("FAIL rand_out i%0d got sout=%b vld=%b busy=%b done=%b exp %b/%b/%b/%b",
                          i, sout, sout_valid, busy, done, m_sout, m_busy, m_busy, m_done);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    rq = '0;
    test_reset();
    test_basic();
    test_en_gaps();
    test_back_to_back();
    test_load_busy();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
